// File: rtl/gelato_reconv_stack_if.sv
// Warp-side bundle for the reconvergence stack: launch, branch and advance
// requests in, live top-of-stack state out.
interface gelato_reconv_stack_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int THREAD_NUM = 32,
    parameter int DEPTH      = 8
);
    localparam int DW = $clog2(DEPTH + 1);

    logic                  init_valid;
    logic [ADDR_WIDTH-1:0] init_pc;
    logic [THREAD_NUM-1:0] init_mask;
    logic                  br_valid;
    logic                  br_ready;
    logic [THREAD_NUM-1:0] br_taken_mask;
    logic [ADDR_WIDTH-1:0] br_taken_pc;
    logic [ADDR_WIDTH-1:0] br_fall_pc;
    logic [ADDR_WIDTH-1:0] br_reconv_pc;
    logic                  adv_valid;
    logic [ADDR_WIDTH-1:0] adv_pc;
    logic                  cur_valid;
    logic [ADDR_WIDTH-1:0] cur_pc;
    logic [THREAD_NUM-1:0] cur_mask;
    logic [DW-1:0]         depth;
    logic                  overflow;

    modport master (
        output init_valid, init_pc, init_mask,
        output br_valid, br_taken_mask, br_taken_pc, br_fall_pc, br_reconv_pc,
        output adv_valid, adv_pc,
        input  br_ready, cur_valid, cur_pc, cur_mask, depth, overflow
    );

    modport slave (
        input  init_valid, init_pc, init_mask,
        input  br_valid, br_taken_mask, br_taken_pc, br_fall_pc, br_reconv_pc,
        input  adv_valid, adv_pc,
        output br_ready, cur_valid, cur_pc, cur_mask, depth, overflow
    );
endinterface

// File: rtl/gelato_reconv_stack.sv
// Per-warp IPDOM divergence/reconvergence stack. Top entry holds the warp's
// live PC and mask; divergent branches push split paths, reaching reconv pops.
module gelato_reconv_stack #(
    parameter int ADDR_WIDTH = 32,
    parameter int THREAD_NUM = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    gelato_reconv_stack_if.slave  bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_WIDTH-1:0] pc_reg   [DEPTH];
    logic [ADDR_WIDTH-1:0] rpc_reg  [DEPTH];
    logic [THREAD_NUM-1:0] mask_reg [DEPTH];
    logic [DW-1:0]         depth_reg;
    logic                  overflow_reg;

    logic                  cur_valid;
    logic [IW-1:0]         top_idx;
    logic [IW-1:0]         n_idx;
    logic [IW-1:0]         t_idx;
    logic [ADDR_WIDTH-1:0] top_pc;
    logic [ADDR_WIDTH-1:0] top_rpc;
    logic [THREAD_NUM-1:0] top_mask;
    logic [THREAD_NUM-1:0] t_mask;
    logic [THREAD_NUM-1:0] n_mask;
    logic                  divergent;
    logic                  br_ready;
    logic                  do_br;
    logic                  do_div;
    logic                  do_ovf;
    logic                  do_adv;
    logic                  do_pop;
    logic                  push_n;
    logic                  push_t;
    logic [ADDR_WIDTH-1:0] new_pc;
    logic [DW-1:0]         depth_next;

    assign cur_valid = (depth_reg != '0);
    assign top_idx   = IW'(depth_reg - DW'(1));
    assign top_pc    = pc_reg[top_idx];
    assign top_rpc   = rpc_reg[top_idx];
    assign top_mask  = mask_reg[top_idx];

    assign t_mask    = bus.br_taken_mask & top_mask;
    assign n_mask    = top_mask & ~t_mask;
    assign divergent = (t_mask != '0) && (n_mask != '0);
    assign br_ready  = cur_valid && (depth_reg <= DW'(DEPTH - 2));

    // Uniform branches behave as a plain advance, so they never need free slots.
    assign do_br   = !bus.init_valid && bus.br_valid && cur_valid;
    assign do_div  = do_br && divergent && br_ready;
    assign do_ovf  = do_br && divergent && !br_ready;
    assign do_adv  = (do_br && !divergent) ||
                     (!bus.init_valid && !bus.br_valid && bus.adv_valid && cur_valid);
    assign new_pc  = do_br ? ((t_mask != '0) ? bus.br_taken_pc : bus.br_fall_pc) : bus.adv_pc;
    assign do_pop  = do_adv && (new_pc == top_rpc) && (depth_reg > DW'(1));

    // A path whose start PC is already the reconv point has nothing to execute.
    assign push_n  = do_div && (bus.br_fall_pc  != bus.br_reconv_pc);
    assign push_t  = do_div && (bus.br_taken_pc != bus.br_reconv_pc);
    assign n_idx   = IW'(depth_reg);
    assign t_idx   = push_n ? IW'(depth_reg + DW'(1)) : IW'(depth_reg);

    always_comb begin
        depth_next = depth_reg;
        if (bus.init_valid) begin
            depth_next = DW'(1);
        end else if (do_div) begin
            depth_next = depth_reg + DW'(push_n) + DW'(push_t);
        end else if (do_pop) begin
            depth_next = depth_reg - DW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            depth_reg <= depth_next;
            if (bus.init_valid) begin
                overflow_reg <= 1'b0;
            end else if (do_ovf) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic is_top;
        assign is_top = cur_valid && (top_idx == IW'(gi));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pc_reg[gi]   <= '0;
                rpc_reg[gi]  <= '0;
                mask_reg[gi] <= '0;
            end else if (bus.init_valid) begin
                if (gi == 0) begin
                    pc_reg[gi]   <= bus.init_pc;
                    rpc_reg[gi]  <= '1;
                    mask_reg[gi] <= bus.init_mask;
                end
            end else if (push_t && (t_idx == IW'(gi))) begin
                pc_reg[gi]   <= bus.br_taken_pc;
                rpc_reg[gi]  <= bus.br_reconv_pc;
                mask_reg[gi] <= t_mask;
            end else if (push_n && (n_idx == IW'(gi))) begin
                pc_reg[gi]   <= bus.br_fall_pc;
                rpc_reg[gi]  <= bus.br_reconv_pc;
                mask_reg[gi] <= n_mask;
            end else if (do_div && is_top) begin
                pc_reg[gi] <= bus.br_reconv_pc;
            end else if (do_adv && !do_pop && is_top) begin
                pc_reg[gi] <= new_pc;
            end
        end
    end

    assign bus.br_ready  = br_ready;
    assign bus.cur_valid = cur_valid;
    assign bus.cur_pc    = cur_valid ? top_pc   : '0;
    assign bus.cur_mask  = cur_valid ? top_mask : '0;
    assign bus.depth     = depth_reg;
    assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_gelato_reconv_stack.sv
// Bench for gelato_reconv_stack (DEPTH=4): vector table plus hand sequences
// for async reset and idle-warp behaviour, checked through a scoreboard queue.
module tb_gelato_reconv_stack;
    localparam int AW = 32;
    localparam int TN = 32;
    localparam int D  = 4;
    localparam int DW = $clog2(D + 1);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] pc;
        logic [TN-1:0] mask;
        logic [DW-1:0] depth;
        logic          ovf;
        logic          ready;
    } exp_t;

    typedef struct {
        string         name;
        logic          iv;
        logic [AW-1:0] ipc;
        logic [TN-1:0] imask;
        logic          bv;
        logic [TN-1:0] tm;
        logic [AW-1:0] tpc;
        logic [AW-1:0] fpc;
        logic [AW-1:0] rpc;
        logic          av;
        logic [AW-1:0] apc;
        exp_t          exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   failures  = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    gelato_reconv_stack_if #(.ADDR_WIDTH(AW), .THREAD_NUM(TN), .DEPTH(D)) bus ();

    gelato_reconv_stack #(.ADDR_WIDTH(AW), .THREAD_NUM(TN), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t e(logic v, logic [AW-1:0] pc, logic [TN-1:0] m,
                               int dep, logic ov, logic rdy);
        exp_t x;
        x.valid = v; x.pc = pc; x.mask = m; x.depth = DW'(dep); x.ovf = ov; x.ready = rdy;
        return x;
    endfunction

    function automatic vec_t mk(string n, logic iv, logic [AW-1:0] ipc, logic [TN-1:0] imask,
                                logic bv, logic [TN-1:0] tm, logic [AW-1:0] tpc,
                                logic [AW-1:0] fpc, logic [AW-1:0] rpc,
                                logic av, logic [AW-1:0] apc, exp_t x);
        vec_t v;
        v.name = n; v.iv = iv; v.ipc = ipc; v.imask = imask; v.bv = bv; v.tm = tm;
        v.tpc = tpc; v.fpc = fpc; v.rpc = rpc; v.av = av; v.apc = apc; v.exp = x;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.init_valid    = v.iv;
        bus.init_pc       = v.ipc;
        bus.init_mask     = v.imask;
        bus.br_valid      = v.bv;
        bus.br_taken_mask = v.tm;
        bus.br_taken_pc   = v.tpc;
        bus.br_fall_pc    = v.fpc;
        bus.br_reconv_pc  = v.rpc;
        bus.adv_valid     = v.av;
        bus.adv_pc        = v.apc;
    endtask

    task automatic check(input string name);
        exp_t act;
        exp_t x;
        act.valid = bus.cur_valid; act.pc = bus.cur_pc; act.mask = bus.cur_mask;
        act.depth = bus.depth; act.ovf = bus.overflow; act.ready = bus.br_ready;
        tests_run++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s: no expected entry queued", name);
            return;
        end
        x = sb_q.pop_front();
        if (act !== x) begin
            failures++;
            $display("FAIL %s: got valid=%0b pc=%h mask=%h depth=%0d ovf=%0b ready=%0b, want valid=%0b pc=%h mask=%h depth=%0d ovf=%0b ready=%0b",
                     name, act.valid, act.pc, act.mask, act.depth, act.ovf, act.ready,
                     x.valid, x.pc, x.mask, x.depth, x.ovf, x.ready);
        end else begin
            $display("[TB] %s: pc=%h mask=%h depth=%0d ovf=%0b ready=%0b ok",
                     name, act.pc, act.mask, act.depth, act.ovf, act.ready);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v);
        sb_q.push_back(v.exp);
        @(posedge clk);
        #1;
        check(v.name);
    endtask

    localparam logic [TN-1:0] ALL = '1;

    initial begin
        vec_t idle;
        idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 0));
        drive(idle);

        // Table: expected values derived by hand from the IPDOM stack rules.
        vecs.push_back(mk("init_root",    1, 32'h100, ALL, 0, 0, 0, 0, 0, 0, 0, e(1, 32'h100, ALL, 1, 0, 1)));
        vecs.push_back(mk("div_both",     0, 0, 0, 1, 32'h0000FFFF, 32'h200, 32'h104, 32'h300, 0, 0, e(1, 32'h200, 32'h0000FFFF, 3, 0, 0)));
        vecs.push_back(mk("pop_taken",    0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h300, e(1, 32'h104, 32'hFFFF0000, 2, 0, 1)));
        vecs.push_back(mk("pop_fall",     0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h300, e(1, 32'h300, ALL, 1, 0, 1)));
        vecs.push_back(mk("if_no_else",   0, 0, 0, 1, 32'hF, 32'h200, 32'h300, 32'h300, 0, 0, e(1, 32'h200, 32'hF, 2, 0, 1)));
        vecs.push_back(mk("adv_inner",    0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h204, e(1, 32'h204, 32'hF, 2, 0, 1)));
        vecs.push_back(mk("uni_taken_in", 0, 0, 0, 1, ALL, 32'h250, 32'h260, 32'h300, 0, 0, e(1, 32'h250, 32'hF, 2, 0, 1)));
        vecs.push_back(mk("uni_fall_pop", 0, 0, 0, 1, 0, 32'h270, 32'h300, 32'h999, 0, 0, e(1, 32'h300, ALL, 1, 0, 1)));
        vecs.push_back(mk("uni_taken",    0, 0, 0, 1, ALL, 32'h400, 32'h404, 32'h500, 0, 0, e(1, 32'h400, ALL, 1, 0, 1)));
        vecs.push_back(mk("hold",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(1, 32'h400, ALL, 1, 0, 1)));
        vecs.push_back(mk("root_no_pop",  0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF, e(1, 32'hFFFFFFFF, ALL, 1, 0, 1)));
        vecs.push_back(mk("fill",         0, 0, 0, 1, 32'h00FF00FF, 32'h600, 32'h604, 32'h700, 0, 0, e(1, 32'h600, 32'h00FF00FF, 3, 0, 0)));
        vecs.push_back(mk("overflow",     0, 0, 0, 1, 32'h000000FF, 32'h800, 32'h804, 32'h900, 0, 0, e(1, 32'h600, 32'h00FF00FF, 3, 1, 0)));
        vecs.push_back(mk("uni_when_full",0, 0, 0, 1, ALL, 32'h610, 32'h614, 32'h900, 0, 0, e(1, 32'h610, 32'h00FF00FF, 3, 1, 0)));
        vecs.push_back(mk("init_prio",    1, 32'h1000, 32'hF, 1, 32'h3, 32'h1100, 32'h1104, 32'h1200, 1, 32'h2000, e(1, 32'h1000, 32'hF, 1, 0, 1)));
        vecs.push_back(mk("nest_outer",   0, 0, 0, 1, 32'h3, 32'h1100, 32'h1200, 32'h1200, 0, 0, e(1, 32'h1100, 32'h3, 2, 0, 1)));
        vecs.push_back(mk("nest_inner",   0, 0, 0, 1, 32'h1, 32'h1150, 32'h1200, 32'h1200, 0, 0, e(1, 32'h1150, 32'h1, 3, 0, 0)));
        vecs.push_back(mk("nest_pop1",    0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1200, e(1, 32'h1200, 32'h3, 2, 0, 1)));
        vecs.push_back(mk("nest_pop2",    0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1200, e(1, 32'h1200, 32'hF, 1, 0, 1)));
        vecs.push_back(mk("skip_t_push",  0, 0, 0, 1, 32'hC, 32'h1300, 32'h1210, 32'h1300, 0, 0, e(1, 32'h1210, 32'h3, 2, 0, 1)));
        vecs.push_back(mk("skip_t_pop",   0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1300, e(1, 32'h1300, 32'hF, 1, 0, 1)));
        vecs.push_back(mk("div_pre_rst",  0, 0, 0, 1, 32'h5, 32'h2000, 32'h2004, 32'h3000, 0, 0, e(1, 32'h2000, 32'h5, 3, 0, 0)));

        // Reset state, sampled while rst is still held.
        #12;
        sb_q.push_back(e(0, 0, 0, 0, 0, 0));
        check("reset_state");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Async reset mid-divergence: outputs must clear with no clock edge.
        @(negedge clk);
        drive(idle);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        sb_q.push_back(e(0, 0, 0, 0, 0, 0));
        check("async_reset");
        @(negedge clk);
        rst = 1'b0;

        // Branch/advance requests with no live warp are ignored.
        apply(mk("idle_warp_req", 0, 0, 0, 1, 32'h3, 32'h40, 32'h44, 32'h48, 1, 32'h50, e(0, 0, 0, 0, 0, 0)));
        apply(mk("relaunch",      1, 32'h80, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 0, e(1, 32'h80, 32'hA5A5A5A5, 1, 0, 1)));

        @(negedge clk);
        drive(idle);
        if (sb_q.size() != 0) begin
            tests_run++;
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
